// File: rtl/cordic_sincos_if.sv
// cordic_sincos_if
//   Request/response bundle for the CORDIC sin/cos engine.
//   x       : signed angle, M integer bits, NBITS-1-M fraction bits
//   M       : integer-bit count, sampled with the request
//   start   : request strobe
//   busy    : engine working on a request
//   done    : one-cycle pulse, sin_out/cos_out valid
//   sin_out : signed sin(x), same format as x
//   cos_out : signed cos(x), same format as x
//   master drives the request side, slave is the engine.
interface cordic_sincos_if #(
    parameter int NBITS = 16
);
    logic signed [NBITS-1:0] x;
    logic signed [31:0]      M;
    logic                    start;
    logic                    busy;
    logic                    done;
    logic signed [NBITS-1:0] sin_out;
    logic signed [NBITS-1:0] cos_out;

    modport master (
        output x, M, start,
        input  busy, done, sin_out, cos_out
    );

    modport slave (
        input  x, M, start,
        output busy, done, sin_out, cos_out
    );
endinterface

// File: rtl/cordic_sincos.sv
// cordic_sincos
//   Iterative CORDIC engine producing sin and cos of one signed fixed-point
//   angle per request. The angle is first folded into [-pi/2, pi/2] by
//   repeated +/-pi steps (tracking a sign flip), then rotated ITER times in
//   an internal Q2.(W-2) format, W = NBITS+GUARD.
//
//   Ports:
//     Clock  : rising-edge clock
//     ResetN : asynchronous active-low reset
//     bus    : cordic_sincos_if.slave (x, M, start in; busy, done,
//              sin_out, cos_out out)
//
//   Optional feature macro:
//     CORDIC_ROUND_EN : round-half-up on output conversion; otherwise the
//                       output is truncated toward minus infinity.
module cordic_sincos #(
    parameter int NBITS = 16,
    parameter int ITER  = 16,
    parameter int GUARD = 4
) (
    input logic            Clock,
    input logic            ResetN,
    cordic_sincos_if.slave bus
);

    localparam int W    = NBITS + GUARD;
    localparam int MMIN = 2;
    localparam int MMAX = NBITS - 4;
    localparam int IW   = (ITER > 1) ? $clog2(ITER) : 1;

    // ---------------------------------------------------------------
    // Elaboration-time constants
    // ---------------------------------------------------------------
    function automatic real pow2(input int e);
        real p;
        p = 1.0;
        if (e >= 0) begin
            for (int k = 0; k < e; k++) p = p * 2.0;
        end else begin
            for (int k = 0; k < -e; k++) p = p / 2.0;
        end
        return p;
    endfunction

    // atan(2^-i); the first few are literal, the rest use a short odd series
    // which is exact far below the table LSB once 2^-i <= 1/16.
    function automatic real atan_real(input int i);
        real t;
        real t2;
        case (i)
            0:       return 0.78539816339744831;
            1:       return 0.46364760900080612;
            2:       return 0.24497866312686414;
            3:       return 0.12435499454676144;
            default: begin
                t  = pow2(-i);
                t2 = t * t;
                return t * (1.0 - t2 * (1.0 / 3.0 - t2 * (1.0 / 5.0
                       - t2 * (1.0 / 7.0 - t2 / 9.0))));
            end
        endcase
    endfunction

    function automatic logic signed [W-1:0] to_fix(input real v, input int fb);
        return W'($rtoi(v * pow2(fb) + 0.5));
    endfunction

    // pi with W-3 fraction bits, i.e. the angle format at M = 2
    localparam logic signed [W-1:0] PI_C = to_fix(3.14159265358979324, W - 3);
    localparam logic signed [W-1:0] K_C  = to_fix(0.6072529350, W - 2);
    localparam logic signed [W:0]   OMAX = (W+1)'((2 ** (NBITS - 1)) - 1);
    localparam logic signed [W:0]   OMIN = -OMAX - 1;

    // Table padded to a power of two so the counter indexes it directly.
    logic signed [W-1:0] atan_rom [2**IW];
    for (genvar g = 0; g < 2**IW; g++) begin : g_atan
        localparam logic signed [W-1:0] A = (g < ITER) ? to_fix(atan_real(g), W - 2) : '0;
        assign atan_rom[g] = A;
    end

    function automatic logic signed [NBITS-1:0] sat(input logic signed [W:0] v);
        if (v > OMAX) return {1'b0, {(NBITS-1){1'b1}}};
        if (v < OMIN) return {1'b1, {(NBITS-1){1'b0}}};
        return v[NBITS-1:0];
    endfunction

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    typedef enum logic [2:0] {IDLE, LOAD, REDUCE, ROTATE, OUT, DONE} state_t;

    state_t state, state_nx;

    logic signed [W-1:0]     theta;
    logic [7:0]              m_r;
    logic                    flip;
    logic signed [W-1:0]     x_r, y_r, z_r;
    logic [IW-1:0]           i_r;
    logic signed [NBITS-1:0] sin_r, cos_r;

    // ---------------------------------------------------------------
    // Combinational datapath
    // ---------------------------------------------------------------
    logic [7:0]              m_ld;
    logic signed [W-1:0]     pi_rt, half_pi;
    logic                    in_band;
    logic signed [W-1:0]     xs, ys, x_nx, y_nx, z_nx;
    logic signed [W:0]       xe, ye, xq, yq;
    logic signed [NBITS-1:0] sin_q, cos_q;
`ifdef CORDIC_ROUND_EN
    logic signed [W:0]       rnd;
`endif

    always_comb begin
        if (bus.M < MMIN)      m_ld = 8'(MMIN);
        else if (bus.M > MMAX) m_ld = 8'(MMAX);
        else                   m_ld = 8'(bus.M);
    end

    always_comb begin
        pi_rt   = PI_C >>> (m_r - 8'd2);
        half_pi = pi_rt >>> 1;
        in_band = (theta <= half_pi) && (theta >= -half_pi);
    end

    always_comb begin
        ys   = y_r >>> i_r;
        xs   = x_r >>> i_r;
        x_nx = z_r[W-1] ? (x_r + ys) : (x_r - ys);
        y_nx = z_r[W-1] ? (y_r - xs) : (y_r + xs);
        z_nx = z_r[W-1] ? (z_r + atan_rom[i_r]) : (z_r - atan_rom[i_r]);
    end

    // One extra bit so negation and the rounding add cannot wrap.
    always_comb begin
        xe = {x_r[W-1], x_r};
        ye = {y_r[W-1], y_r};
        if (flip) begin
            xe = -xe;
            ye = -ye;
        end
`ifdef CORDIC_ROUND_EN
        rnd = (W+1)'(1) << (m_r - 8'd2 + 8'(GUARD));
        xe  = xe + rnd;
        ye  = ye + rnd;
`endif
        xq    = xe >>> (m_r - 8'd1 + 8'(GUARD));
        yq    = ye >>> (m_r - 8'd1 + 8'(GUARD));
        cos_q = sat(xq);
        sin_q = sat(yq);
    end

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.start) state_nx = LOAD;
            LOAD:    state_nx = REDUCE;
            REDUCE:  if (in_band) state_nx = ROTATE;
            ROTATE:  if (i_r == IW'(ITER - 1)) state_nx = OUT;
            OUT:     state_nx = DONE;
            DONE:    state_nx = bus.start ? LOAD : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            theta <= '0;
            m_r   <= 8'(MMIN);
            flip  <= 1'b0;
            x_r   <= '0;
            y_r   <= '0;
            z_r   <= '0;
            i_r   <= '0;
            sin_r <= '0;
            cos_r <= '0;
        end else begin
            unique case (state)
                LOAD: begin
                    theta <= $signed({bus.x, {GUARD{1'b0}}});
                    m_r   <= m_ld;
                    flip  <= 1'b0;
                end
                REDUCE: begin
                    if (theta > half_pi) begin
                        theta <= theta - pi_rt;
                        flip  <= ~flip;
                    end else if (theta < -half_pi) begin
                        theta <= theta + pi_rt;
                        flip  <= ~flip;
                    end else begin
                        // The rotation is set up on the exit cycle itself so
                        // ROTATE spends exactly ITER cycles iterating.
                        z_r <= theta <<< (m_r - 8'd1);
                        x_r <= K_C;
                        y_r <= '0;
                        i_r <= '0;
                    end
                end
                ROTATE: begin
                    x_r <= x_nx;
                    y_r <= y_nx;
                    z_r <= z_nx;
                    i_r <= i_r + 1'b1;
                end
                OUT: begin
                    sin_r <= sin_q;
                    cos_r <= cos_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (state == LOAD) || (state == REDUCE) ||
                         (state == ROTATE) || (state == OUT);
    assign bus.done    = (state == DONE);
    assign bus.sin_out = sin_r;
    assign bus.cos_out = cos_r;

endmodule

// File: tb/tb_cordic_sincos.sv
// tb_cordic_sincos
//   Self-checking bench for cordic_sincos (NBITS=16, ITER=16, GUARD=4).
//   Expected results come from real-valued $sin/$cos of the decoded angle.
module tb_cordic_sincos;

    localparam int  NBITS = 16;
    localparam int  ITER  = 16;
    localparam int  GUARD = 4;
    localparam real PI    = 3.14159265358979324;
`ifdef CORDIC_ROUND_EN
    localparam real TOL = 1.0;
`else
    localparam real TOL = 2.0;
`endif

    logic Clock = 1'b0;
    logic ResetN;

    always #5 Clock = ~Clock;

    cordic_sincos_if #(.NBITS(NBITS)) bus ();

    cordic_sincos #(
        .NBITS(NBITS),
        .ITER (ITER),
        .GUARD(GUARD)
    ) dut (
        .Clock (Clock),
        .ResetN(ResetN),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // ---------------- reference model ----------------
    function automatic int eff_m(input int m);
        if (m < 2) return 2;
        if (m > NBITS - 4) return NBITS - 4;
        return m;
    endfunction

    function automatic real scale_of(input int m);
        real p;
        p = 1.0;
        for (int k = 0; k < NBITS - 1 - eff_m(m); k++) p = p * 2.0;
        return p;
    endfunction

    function automatic real ref_trig(input int xv, input int m, input bit want_sin);
        real sc, a, r;
        sc = scale_of(m);
        a  = real'(xv) / sc;
        r  = (want_sin ? $sin(a) : $cos(a)) * sc;
        if (r > 32767.0)  r = 32767.0;
        if (r < -32768.0) r = -32768.0;
        return r;
    endfunction

    function automatic real rabs(input real v);
        return (v < 0.0) ? -v : v;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Issue one request and wait for done; lat = edges after the start edge
    // until done is visible, -1 if it never came.
    task automatic run_req(input int xv, input int mv,
                           output int lat, output int s, output int c);
        @(negedge Clock);
        bus.x     = 16'(xv);
        bus.M     = mv;
        bus.start = 1'b1;
        @(posedge Clock);
        #1 bus.start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 3000 && lat < 0; k++) begin
            @(posedge Clock);
            #1;
            if (bus.done === 1'b1) lat = k;
        end
        s = int'(bus.sin_out);
        c = int'(bus.cos_out);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        ResetN    = 1'b0;
        bus.start = 1'b0;
        bus.x     = '0;
        bus.M     = 6;
        repeat (3) @(posedge Clock);
        #1;
        tests++;
        if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        tests++;
        if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        tests++;
        if (bus.sin_out !== 16'sd0) begin fails++; $display("FAIL reset_sin: got %0d expected 0", bus.sin_out); end
        tests++;
        if (bus.cos_out !== 16'sd0) begin fails++; $display("FAIL reset_cos: got %0d expected 0", bus.cos_out); end
        @(negedge Clock);
        ResetN = 1'b1;
    endtask

    task automatic test_directed();
        int dx [5] = '{0, 804, -268, 1608, 10240};
        int dr [5] = '{0, 0, 0, 1, 6};
        int ds [5] = '{0, 512, -256, 0, 467};
        int dc [5] = '{512, 0, 443, -512, 209};
        int dt [5] = '{1, 1, 1, 1, 2};
        int lat, s, c;
        for (int n = 0; n < 5; n++) begin
            run_req(dx[n], 6, lat, s, c);
            tests++;
            if (lat !== ITER + dr[n] + 3) begin
                fails++; $display("FAIL dir_latency x=%0d: got %0d expected %0d", dx[n], lat, ITER + dr[n] + 3);
            end
            tests++;
            if (iabs(s - ds[n]) > dt[n]) begin
                fails++; $display("FAIL dir_sin x=%0d: got %0d expected %0d +/-%0d", dx[n], s, ds[n], dt[n]);
            end
            tests++;
            if (iabs(c - dc[n]) > dt[n]) begin
                fails++; $display("FAIL dir_cos x=%0d: got %0d expected %0d +/-%0d", dx[n], c, dc[n], dt[n]);
            end
            @(posedge Clock);
            #1;
            tests++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                fails++; $display("FAIL dir_pulse x=%0d: got done=%b busy=%b expected 0/0", dx[n], bus.done, bus.busy);
            end
            tests++;
            if (int'(bus.sin_out) !== s || int'(bus.cos_out) !== c) begin
                fails++; $display("FAIL dir_hold x=%0d: got %0d/%0d expected %0d/%0d", dx[n], bus.sin_out, bus.cos_out, s, c);
            end
        end
    endtask

    task automatic test_random();
        int xv, lat, s, c;
        real rs, rc;
        for (int n = 0; n < 30; n++) begin
            xv = int'($urandom_range(32000)) - 16000;
            run_req(xv, 6, lat, s, c);
            rs = ref_trig(xv, 6, 1'b1);
            rc = ref_trig(xv, 6, 1'b0);
            tests++;
            if (lat < ITER + 3 || lat > ITER + 3 + 21) begin
                fails++; $display("FAIL rand_latency x=%0d: got %0d expected %0d..%0d", xv, lat, ITER + 3, ITER + 24);
            end
            tests++;
            if (rabs(real'(s) - rs) > 2.0) begin
                fails++; $display("FAIL rand_sin x=%0d: got %0d expected %f +/-2", xv, s, rs);
            end
            tests++;
            if (rabs(real'(c) - rc) > 2.0) begin
                fails++; $display("FAIL rand_cos x=%0d: got %0d expected %f +/-2", xv, c, rc);
            end
        end
    endtask

    task automatic test_m_clamp();
        int mx [2] = '{20, 0};
        int xx [2] = '{12, 4096};
        real tl [2] = '{1.0, 3.0};
        int lat, s, c;
        real rs, rc;
        for (int n = 0; n < 2; n++) begin
            run_req(xx[n], mx[n], lat, s, c);
            rs = ref_trig(xx[n], mx[n], 1'b1);
            rc = ref_trig(xx[n], mx[n], 1'b0);
            tests++;
            if (lat !== ITER + 3) begin
                fails++; $display("FAIL clamp_latency M=%0d: got %0d expected %0d", mx[n], lat, ITER + 3);
            end
            tests++;
            if (rabs(real'(s) - rs) > tl[n]) begin
                fails++; $display("FAIL clamp_sin M=%0d: got %0d expected %f", mx[n], s, rs);
            end
            tests++;
            if (rabs(real'(c) - rc) > tl[n]) begin
                fails++; $display("FAIL clamp_cos M=%0d: got %0d expected %f", mx[n], c, rc);
            end
        end
    endtask

    task automatic test_ignore_start();
        int ndone = 0;
        int s = 0, c = 0;
        @(negedge Clock);
        bus.x = 16'sd804; bus.M = 6; bus.start = 1'b1;
        @(posedge Clock);
        #1 bus.start = 1'b0;
        repeat (5) @(posedge Clock);
        @(negedge Clock);
        bus.x = -16'sd268; bus.start = 1'b1;
        @(posedge Clock);
        #1 bus.start = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(posedge Clock);
            #1;
            if (bus.done === 1'b1) begin
                ndone++;
                s = int'(bus.sin_out);
                c = int'(bus.cos_out);
            end
        end
        tests++;
        if (ndone !== 1) begin fails++; $display("FAIL ignore_count: got %0d done pulses expected 1", ndone); end
        tests++;
        if (iabs(s - 512) > 1) begin fails++; $display("FAIL ignore_sin: got %0d expected 512 +/-1", s); end
        tests++;
        if (iabs(c) > 1) begin fails++; $display("FAIL ignore_cos: got %0d expected 0 +/-1", c); end
    endtask

    task automatic test_back_to_back();
        int  t = 0, last_t = 0, xv, rx;
        bit  got;
        real rs, rc;
        @(negedge Clock);
        bus.x = '0; bus.M = 6; bus.start = 1'b1;
        for (int idx = 0; idx < 11; idx++) begin
            got = 1'b0;
            for (int k = 0; k < 200 && !got; k++) begin
                @(posedge Clock);
                #1;
                t++;
                if (bus.done === 1'b1) got = 1'b1;
            end
            xv = idx * 160;
            rx = (real'(xv) / 512.0 > PI / 2.0) ? 1 : 0;
            rs = ref_trig(xv, 6, 1'b1);
            rc = ref_trig(xv, 6, 1'b0);
            tests++;
            if (!got) begin fails++; $display("FAIL b2b_timeout x=%0d: got no done expected done", xv); end
            tests++;
            if (idx == 0) begin
                if (t !== ITER + rx + 4) begin fails++; $display("FAIL b2b_first x=%0d: got %0d expected %0d", xv, t, ITER + rx + 4); end
            end else if (t - last_t !== ITER + rx + 4) begin
                fails++; $display("FAIL b2b_gap x=%0d: got %0d expected %0d", xv, t - last_t, ITER + rx + 4);
            end
            tests++;
            if (rabs(real'(bus.sin_out) - rs) > TOL) begin
                fails++; $display("FAIL b2b_sin x=%0d: got %0d expected %f", xv, bus.sin_out, rs);
            end
            tests++;
            if (rabs(real'(bus.cos_out) - rc) > TOL) begin
                fails++; $display("FAIL b2b_cos x=%0d: got %0d expected %f", xv, bus.cos_out, rc);
            end
            last_t = t;
            if (idx < 10) bus.x = 16'((idx + 1) * 160);
            else          bus.start = 1'b0;
        end
        repeat (2) @(posedge Clock);
    endtask

    task automatic test_reset_mid_reduce();
        int lat, s, c;
        @(negedge Clock);
        bus.x = 16'sd10240; bus.M = 6; bus.start = 1'b1;
        @(posedge Clock);
        #1 bus.start = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        tests++;
        if (bus.busy !== 1'b1) begin fails++; $display("FAIL rst_inflight: got busy=%b expected 1", bus.busy); end
        #1 ResetN = 1'b0;
        #1;
        tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            fails++; $display("FAIL rst_ctrl: got busy=%b done=%b expected 0/0", bus.busy, bus.done);
        end
        tests++;
        if (bus.sin_out !== 16'sd0 || bus.cos_out !== 16'sd0) begin
            fails++; $display("FAIL rst_data: got %0d/%0d expected 0/0", bus.sin_out, bus.cos_out);
        end
        @(posedge Clock);
        @(negedge Clock);
        ResetN = 1'b1;
        run_req(804, 6, lat, s, c);
        tests++;
        if (lat !== ITER + 3) begin fails++; $display("FAIL rst_next_latency: got %0d expected %0d", lat, ITER + 3); end
        tests++;
        if (iabs(s - 512) > 1 || iabs(c) > 1) begin
            fails++; $display("FAIL rst_next_value: got %0d/%0d expected 512/0 +/-1", s, c);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_m_clamp();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_reduce();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1);
    end

endmodule
